lm_sm_sequencer: RTL and testbench

- Decode-side micro-sequencer between the IF-ID pipeline register and the control decoder / register-read stage.
- Passes ordinary instructions through with 1 cycle of registered latency.
- Expands LM (load multiple) and SM (store multiple) into a series of single LW/SW micro-ops, one per set bit of the 8-bit register list.
- While expanding, holds the fetch stage and IF-ID so the LM/SM instruction is consumed exactly once.

---
 rtl/lm_sm_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_lm_sm_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lm_sm_sequencer.sv
// Decode-side micro-sequencer that expands LM/SM into one LW/SW micro-op per set list bit.
// Latency: 1 registered cycle for pass-through; an LM/SM retires in max(N,1) non-stalled cycles.
// Backpressure: stall freezes all state; fetch_hold holds IF-ID while later micro-ops are still pending.
//
// Ports:
//   clk, reset         - clock and synchronous active-high reset
//   instr_in, pc_in    - instruction and its PC from IF-ID; instr_valid marks a real instruction
//   stall, flush       - hazard hold (freeze) and squash (discard any expansion)
//   uop_instr/uop_pc   - registered micro-op (or pass-through instruction) and parent PC
//   uop_valid/first/last - qualifiers for uop_instr
//   fetch_hold         - combinational; keeps PC and IF-ID from advancing
//   busy               - sequencer is in the middle of an expansion
module lm_sm_sequencer #(
  parameter logic [3:0]  LM_OPCODE = 4'b0110,
  parameter logic [3:0]  SM_OPCODE = 4'b0111,
  parameter logic [3:0]  LW_OPCODE = 4'b0100,
  parameter logic [3:0]  SW_OPCODE = 4'b0101,
  parameter logic [15:0] NOP_INSTR = 16'hF000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_in,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] uop_instr,
  output logic [15:0] uop_pc,
  output logic        uop_valid,
  output logic        uop_first,
  output logic        uop_last,
  output logic        fetch_hold,
  output logic        busy
);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t      state_q, state_d;
  logic [7:0]  mask_q, mask_d;     // list bits not yet issued
  logic [7:0]  list_q, list_d;     // original list, needed for rank()
  logic [2:0]  base_q, base_d;
  logic        is_lm_q, is_lm_d;

  logic [15:0] uop_instr_d, uop_pc_d;
  logic        uop_valid_d, uop_first_d, uop_last_d;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, v[i]};
    return c;
  endfunction

  // Lowest remaining register, except that an LM's base register is held
  // back until it is the only one left so earlier loads see the old base.
  function automatic logic [2:0] pick(input logic [7:0] mask, input logic [2:0] base,
                                      input logic is_lm);
    logic [7:0] cand;
    logic [2:0] idx;
    cand = mask;
    if (is_lm && mask[base] && ((mask & ~(8'b1 << base)) != 8'd0))
      cand = mask & ~(8'b1 << base);
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (cand[i]) idx = 3'(i);
    return idx;
  endfunction

  // Offset is the register's rank within the original list, so it does not
  // change when the base register is reordered to the end.
  function automatic logic [15:0] uop_word(input logic is_lm, input logic [2:0] idx,
                                           input logic [2:0] base, input logic [7:0] list);
    logic [2:0] rank;
    rank = 3'd0;
    for (int j = 0; j < 8; j++) if ((j < int'(idx)) && list[j]) rank = rank + 3'd1;
    return {(is_lm ? LW_OPCODE : SW_OPCODE), idx, base, 3'b000, rank};
  endfunction

  // Field decode of the incoming instruction.
  logic [3:0] in_op;
  logic [2:0] in_base;
  logic [7:0] in_list;
  logic       in_is_lm, in_is_ms;
  logic [3:0] in_n;

  assign in_op    = instr_in[15:12];
  assign in_base  = instr_in[11:9];
  assign in_list  = instr_in[7:0];
  assign in_is_lm = (in_op == LM_OPCODE);
  assign in_is_ms = in_is_lm || (in_op == SM_OPCODE);
  assign in_n     = popcnt8(in_list);

  // Source of the next micro-op: the live instruction in IDLE, captured copy in EXPAND.
  logic [7:0]  src_mask, src_list, rem_mask;
  logic [2:0]  src_base, sel_idx;
  logic        src_is_lm;
  logic [15:0] sel_word;

  always_comb begin
    src_mask  = in_list;
    src_list  = in_list;
    src_base  = in_base;
    src_is_lm = in_is_lm;
    if (state_q == EXPAND) begin
      src_mask  = mask_q;
      src_list  = list_q;
      src_base  = base_q;
      src_is_lm = is_lm_q;
    end
    sel_idx  = pick(src_mask, src_base, src_is_lm);
    sel_word = uop_word(src_is_lm, sel_idx, src_base, src_list);
    rem_mask = src_mask & ~(8'b1 << sel_idx);
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    list_d      = list_q;
    base_d      = base_q;
    is_lm_d     = is_lm_q;
    uop_instr_d = NOP_INSTR;
    uop_pc_d    = uop_pc;
    uop_valid_d = 1'b0;
    uop_first_d = 1'b0;
    uop_last_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          if (!in_is_ms) begin
            uop_instr_d = instr_in;
            uop_pc_d    = pc_in;
            uop_valid_d = 1'b1;
            uop_first_d = 1'b1;
            uop_last_d  = 1'b1;
          end else if (in_n != 4'd0) begin
            uop_instr_d = sel_word;
            uop_pc_d    = pc_in;
            uop_valid_d = 1'b1;
            uop_first_d = 1'b1;
            uop_last_d  = (rem_mask == 8'd0);
            if (rem_mask != 8'd0) begin
              state_d = EXPAND;
              mask_d  = rem_mask;
              list_d  = in_list;
              base_d  = in_base;
              is_lm_d = in_is_lm;
            end
          end
        end
      end
      EXPAND: begin
        uop_instr_d = sel_word;
        uop_valid_d = 1'b1;
        uop_last_d  = (rem_mask == 8'd0);
        mask_d      = rem_mask;
        if (rem_mask == 8'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mask_q    <= 8'd0;
      list_q    <= 8'd0;
      base_q    <= 3'd0;
      is_lm_q   <= 1'b0;
      uop_instr <= NOP_INSTR;
      uop_pc    <= 16'd0;
      uop_valid <= 1'b0;
      uop_first <= 1'b0;
      uop_last  <= 1'b0;
    end else if (flush) begin
      state_q   <= IDLE;
      mask_q    <= 8'd0;
      uop_instr <= NOP_INSTR;
      uop_valid <= 1'b0;
    end else if (!stall) begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      list_q    <= list_d;
      base_q    <= base_d;
      is_lm_q   <= is_lm_d;
      uop_instr <= uop_instr_d;
      uop_pc    <= uop_pc_d;
      uop_valid <= uop_valid_d;
      uop_first <= uop_first_d;
      uop_last  <= uop_last_d;
    end
  end

  // Hold IF-ID while at least one micro-op remains after the coming edge,
  // so it advances on exactly the edge that emits the final micro-op.
  always_comb begin
    fetch_hold = 1'b0;
    if (!reset) begin
      if (state_q == IDLE)
        fetch_hold = instr_valid && in_is_ms && (in_n >= 4'd2);
      else
        fetch_hold = (popcnt8(mask_q) >= 4'd2);
    end
  end

  assign busy = (state_q == EXPAND);

endmodule

// File: tb/tb_lm_sm_sequencer.sv
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr_in, pc_in;
  logic        instr_valid, stall, flush;
  logic [15:0] uop_instr, uop_pc;
  logic        uop_valid, uop_first, uop_last, fetch_hold, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // {instr, pc, first, last}
  logic [33:0] exp_q[$];
  logic        adv = 1'b0;

  lm_sm_sequencer dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
    .instr_valid(instr_valid), .stall(stall), .flush(flush),
    .uop_instr(uop_instr), .uop_pc(uop_pc), .uop_valid(uop_valid),
    .uop_first(uop_first), .uop_last(uop_last),
    .fetch_hold(fetch_hold), .busy(busy)
  );

  always #5 clk = ~clk;

  // An edge produces a new micro-op only when it was not stalled.
  always @(posedge clk) adv <= !stall;

  // Monitor: every freshly presented valid micro-op must match the queue head.
  always @(negedge clk) begin
    if (uop_valid === 1'b1 && adv) begin
      logic [33:0] got, want;
      got = {uop_instr, uop_pc, uop_first, uop_last};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL uop_unexpected: got instr=%h pc=%h first=%b last=%b, required none",
                 uop_instr, uop_pc, uop_first, uop_last);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL uop_match: got instr=%h pc=%h first=%b last=%b, required instr=%h pc=%h first=%b last=%b",
                   got[33:18], got[17:2], got[1], got[0], want[33:18], want[17:2], want[1], want[0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] i, input logic [15:0] p, input logic v);
    instr_in = i; pc_in = p; instr_valid = v;
    #1;
  endtask

  task automatic expect_uop(input logic [15:0] i, input logic [15:0] p,
                            input logic f, input logic l);
    exp_q.push_back({i, p, f, l});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    instr_in = 16'h0000; pc_in = 16'h0000; instr_valid = 1'b0;
    tick(); tick();
    check("reset_valid", 32'(uop_valid), 32'd0);
    check("reset_instr", 32'(uop_instr), 32'hF000);
    check("reset_pc",    32'(uop_pc),    32'd0);
    check("reset_first", 32'(uop_first), 32'd0);
    check("reset_last",  32'(uop_last),  32'd0);
    check("reset_busy",  32'(busy),      32'd0);
    reset = 1'b0;

    // Pass-through
    drive(16'h1234, 16'h0010, 1'b1);
    check("pass_hold", 32'(fetch_hold), 32'd0);
    expect_uop(16'h1234, 16'h0010, 1'b1, 1'b1);
    tick();
    drive(16'h0000, 16'h0000, 1'b0);
    check("pass_valid", 32'(uop_valid), 32'd1);
    tick();
    check("bubble_valid", 32'(uop_valid), 32'd0);
    check("bubble_instr", 32'(uop_instr), 32'hF000);

    // LM with base in list: R0, R3, then base R2 last
    drive(16'h640D, 16'h0020, 1'b1);
    check("lm_hold0", 32'(fetch_hold), 32'd1);
    check("lm_busy0", 32'(busy), 32'd0);
    expect_uop(16'h4080, 16'h0020, 1'b1, 1'b0);
    expect_uop(16'h4682, 16'h0020, 1'b0, 1'b0);
    expect_uop(16'h4481, 16'h0020, 1'b0, 1'b1);
    tick();
    check("lm_hold1", 32'(fetch_hold), 32'd1);
    check("lm_busy1", 32'(busy), 32'd1);
    tick();
    check("lm_hold2", 32'(fetch_hold), 32'd0);
    check("lm_busy2", 32'(busy), 32'd1);
    tick();
    check("lm_busy3", 32'(busy), 32'd0);

    // SM, two registers including R7
    drive(16'h7281, 16'h0030, 1'b1);
    check("sm_hold0", 32'(fetch_hold), 32'd1);
    expect_uop(16'h5040, 16'h0030, 1'b1, 1'b0);
    expect_uop(16'h5E41, 16'h0030, 1'b0, 1'b1);
    tick();
    check("sm_hold1", 32'(fetch_hold), 32'd0);
    check("sm_busy1", 32'(busy), 32'd1);
    drive(16'h0000, 16'h0000, 1'b0);
    tick();
    check("sm_busy2", 32'(busy), 32'd0);

    // Empty list: dropped
    drive(16'h6000, 16'h0040, 1'b1);
    check("empty_hold", 32'(fetch_hold), 32'd0);
    tick();
    check("empty_valid", 32'(uop_valid), 32'd0);
    check("empty_busy",  32'(busy), 32'd0);

    // Single-register LM: one micro-op, no hold
    drive(16'h6004, 16'h0050, 1'b1);
    check("single_hold", 32'(fetch_hold), 32'd0);
    expect_uop(16'h4400, 16'h0050, 1'b1, 1'b1);
    tick();
    check("single_busy", 32'(busy), 32'd0);
    drive(16'h0000, 16'h0000, 1'b0);
    tick();

    // Stall mid-expansion
    drive(16'h640D, 16'h0060, 1'b1);
    expect_uop(16'h4080, 16'h0060, 1'b1, 1'b0);
    expect_uop(16'h4682, 16'h0060, 1'b0, 1'b0);
    expect_uop(16'h4481, 16'h0060, 1'b0, 1'b1);
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_instr", 32'(uop_instr), 32'h4080);
      check("stall_hold",  32'(fetch_hold), 32'd1);
    end
    stall = 1'b0;
    tick();
    tick();
    drive(16'h0000, 16'h0000, 1'b0);
    tick();
    check("stall_done_busy", 32'(busy), 32'd0);

    // Flush mid-expansion, then a fresh instruction is accepted
    drive(16'h640D, 16'h0070, 1'b1);
    expect_uop(16'h4080, 16'h0070, 1'b1, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", 32'(uop_valid), 32'd0);
    check("flush_instr", 32'(uop_instr), 32'hF000);
    check("flush_busy",  32'(busy), 32'd0);
    drive(16'h1234, 16'h0080, 1'b1);
    expect_uop(16'h1234, 16'h0080, 1'b1, 1'b1);
    tick();
    drive(16'h0000, 16'h0000, 1'b0);
    tick();

    // Reset mid-expansion
    drive(16'h640D, 16'h0090, 1'b1);
    expect_uop(16'h4080, 16'h0090, 1'b1, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    check("reset_hold_forced", 32'(fetch_hold), 32'd0);
    tick();
    reset = 1'b0;
    drive(16'h0000, 16'h0000, 1'b0);
    check("rst2_valid", 32'(uop_valid), 32'd0);
    check("rst2_instr", 32'(uop_instr), 32'hF000);
    check("rst2_pc",    32'(uop_pc),    32'd0);
    check("rst2_first", 32'(uop_first), 32'd0);
    check("rst2_last",  32'(uop_last),  32'd0);
    check("rst2_busy",  32'(busy),      32'd0);
    tick();
    tick();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
